cache_control: RTL and testbench

Sequencing FSM for the 2-way, 8-set, write-back/write-allocate L1 cache. It sits between the CPU memory handshake and the physical-memory handshake, and it drives every load/select strobe of the cache datapath from that datapath's `cache_hit`, `dirty` and `valid` status. It also keeps 16-bit saturating hit, miss and writeback counters for performance debug.

---
 rtl/cache_control.sv | 142 ++++++++++++++
 tb/tb_cache_control.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_control.sv
// Sequencing FSM for the 2-way write-back L1 cache.
// Drives datapath strobes and keeps saturating perf counters.
module cache_control #(
  parameter int CTR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic             pmem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             cache_hit,
  input  logic             dirty,
  input  logic             valid,
  output logic             load_data_valid_dirty,
  output logic             load_tag,
  output logic             lru_or_way,
  output logic [1:0]       loadlrumux_sel,
  output logic             dirty_val,
  output logic             datainmux_sel,
  input  logic             ctr_clear,
  output logic [CTR_W-1:0] hit_count,
  output logic [CTR_W-1:0] miss_count,
  output logic [CTR_W-1:0] wb_count
);

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             miss_pend_q, miss_pend_d;
  logic [CTR_W-1:0] hit_q, hit_d;
  logic [CTR_W-1:0] miss_q, miss_d;
  logic [CTR_W-1:0] wb_q, wb_d;
  logic             hit_inc, miss_inc, wb_inc;
  logic             req;

  assign req = mem_read | mem_write;

  function automatic logic [CTR_W-1:0] sat_next(
    input logic [CTR_W-1:0] q,
    input logic             inc,
    input logic             clr
  );
    logic [CTR_W-1:0] r;
    r = q;
    if (clr)
      r = '0;
    else if (inc && (q != {CTR_W{1'b1}}))
      r = q + 1'b1;
    return r;
  endfunction

  // Next state, datapath strobes and counter increments.
  always_comb begin
    state_d               = state_q;
    miss_pend_d           = miss_pend_q;
    mem_resp              = 1'b0;
    pmem_read             = 1'b0;
    pmem_write            = 1'b0;
    load_data_valid_dirty = 1'b0;
    load_tag              = 1'b0;
    lru_or_way            = 1'b0;
    loadlrumux_sel        = 2'b00;
    dirty_val             = 1'b0;
    datainmux_sel         = 1'b0;
    hit_inc               = 1'b0;
    miss_inc              = 1'b0;
    wb_inc                = 1'b0;
    unique case (state_q)
      CHECK: begin
        if (req) begin
          if (cache_hit) begin
            mem_resp       = 1'b1;
            loadlrumux_sel = 2'b10;
            lru_or_way     = 1'b1;
            if (mem_write) begin
              load_data_valid_dirty = 1'b1;
              datainmux_sel         = 1'b1;
              dirty_val             = 1'b1;
            end
            hit_inc     = ~miss_pend_q;
            miss_pend_d = 1'b0;
          end else begin
            miss_pend_d = 1'b1;
            miss_inc    = 1'b1;
            if (valid & dirty) begin
              wb_inc  = 1'b1;
              state_d = WRITEBACK;
            end else begin
              state_d = ALLOCATE;
            end
          end
        end
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        if (pmem_resp)
          state_d = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          load_data_valid_dirty = 1'b1;
          load_tag              = 1'b1;
          state_d               = CHECK;
        end
      end
      default: state_d = CHECK;
    endcase
    hit_d  = sat_next(hit_q, hit_inc, ctr_clear);
    miss_d = sat_next(miss_q, miss_inc, ctr_clear);
    wb_d   = sat_next(wb_q, wb_inc, ctr_clear);
  end

  // State, pending-miss flag and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CHECK;
      miss_pend_q <= 1'b0;
      hit_q       <= '0;
      miss_q      <= '0;
      wb_q        <= '0;
    end else begin
      state_q     <= state_d;
      miss_pend_q <= miss_pend_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      wb_q        <= wb_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign wb_count   = wb_q;

endmodule

// File: tb/tb_cache_control.sv
// Bench for cache_control: transaction-level model,
// directed plus randomized accesses.
module tb_cache_control;

  logic clk = 1'b0;
  logic rst, mem_read, mem_write, pmem_resp;
  logic cache_hit, dirty, valid, ctr_clear;
  logic mem_resp, pmem_read, pmem_write;
  logic ld, lt, lw, dv, dm;
  logic [1:0] ls;
  logic [15:0] hc, mc, wc;
  logic s_mr, s_pr, s_pw, s_ld, s_lt, s_lw, s_dv, s_dm;
  logic [1:0] s_ls;
  logic [2:0] s_hc, s_mc, s_wc;
  logic [9:0] outs;

  int checks = 0;
  int fails = 0;
  int m_hit = 0, m_miss = 0, m_wb = 0;
  bit pend = 0;

  always #5 clk = ~clk;

  cache_control dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .pmem_resp(pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .cache_hit(cache_hit), .dirty(dirty), .valid(valid),
    .load_data_valid_dirty(ld), .load_tag(lt),
    .lru_or_way(lw), .loadlrumux_sel(ls),
    .dirty_val(dv), .datainmux_sel(dm),
    .ctr_clear(ctr_clear),
    .hit_count(hc), .miss_count(mc), .wb_count(wc)
  );

  cache_control #(.CTR_W(3)) dut_s (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(s_mr), .pmem_resp(pmem_resp),
    .pmem_read(s_pr), .pmem_write(s_pw),
    .cache_hit(cache_hit), .dirty(dirty), .valid(valid),
    .load_data_valid_dirty(s_ld), .load_tag(s_lt),
    .lru_or_way(s_lw), .loadlrumux_sel(s_ls),
    .dirty_val(s_dv), .datainmux_sel(s_dm),
    .ctr_clear(ctr_clear),
    .hit_count(s_hc), .miss_count(s_mc), .wb_count(s_wc)
  );

  assign outs = {mem_resp, pmem_read, pmem_write, ld, lt,
                 lw, ls, dv, dm};

  function automatic logic [9:0] pk(
    bit mr, bit pr, bit pw, bit l, bit t, bit w,
    logic [1:0] s, bit d, bit m);
    return {mr, pr, pw, l, t, w, s, d, m};
  endfunction

  function automatic int sat(int n, int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=%0h expected=%0h",
               tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctrs();
    chk("hit_count", {16'd0, hc}, sat(m_hit, 16));
    chk("miss_count", {16'd0, mc}, sat(m_miss, 16));
    chk("wb_count", {16'd0, wc}, sat(m_wb, 16));
    chk("hit_count_w3", {29'd0, s_hc}, sat(m_hit, 3));
    chk("miss_count_w3", {29'd0, s_mc}, sat(m_miss, 3));
    chk("wb_count_w3", {29'd0, s_wc}, sat(m_wb, 3));
  endtask

  // One CPU access; hit or miss path chosen by the status bits.
  task automatic access(input bit rd, input bit wr,
                        input bit hit, input bit v,
                        input bit d, input int wbl,
                        input int fl, input bit clr);
    bit w;
    bit lst;
    int guard;
    w = wr;
    mem_read = rd;
    mem_write = wr;
    cache_hit = hit;
    valid = v;
    dirty = d;
    ctr_clear = clr;
    @(negedge clk);
    if (hit) begin
      chk("hit_outs", outs, pk(1, 0, 0, w, 0, 1, 2'b10, w, w));
      tick();
      if (clr) begin
        m_hit = 0; m_miss = 0; m_wb = 0;
      end else if (!pend) begin
        m_hit++;
      end
      pend = 0;
    end else begin
      chk("miss_c0_outs", outs, 10'd0);
      tick();
      if (clr) begin
        m_hit = 0; m_miss = 0; m_wb = 0;
      end else begin
        m_miss++;
        if (v && d) m_wb++;
      end
      pend = 1;
      ctr_clear = 0;
      cache_hit = 0;
      if (v && d) begin
        for (int i = 0; i < wbl; i++) begin
          pmem_resp = (i == wbl - 1);
          @(negedge clk);
          chk("wb_outs", outs, pk(0, 0, 1, 0, 0, 0, 2'b00, 0, 0));
          tick();
        end
      end
      guard = 0;
      for (int i = 0; i < fl; i++) begin
        lst = (i == fl - 1);
        pmem_resp = lst;
        @(negedge clk);
        chk("fill_outs", outs,
            pk(0, 1, 0, lst, lst, 0, 2'b00, 0, 0));
        tick();
        guard++;
      end
      pmem_resp = 0;
      cache_hit = 1;
      valid = 1;
      dirty = w;
      @(negedge clk);
      chk("refill_hit_outs", outs,
          pk(1, 0, 0, w, 0, 1, 2'b10, w, w));
      tick();
      pend = 0;
    end
    mem_read = 0;
    mem_write = 0;
    cache_hit = 0;
    ctr_clear = 0;
    @(negedge clk);
    chk("idle_outs", outs, 10'd0);
    chk_ctrs();
    tick();
  endtask

  initial begin
    rst = 1; mem_read = 0; mem_write = 0; pmem_resp = 0;
    cache_hit = 0; dirty = 0; valid = 0; ctr_clear = 0;
    tick();
    tick();
    rst = 0;
    @(negedge clk);
    chk("reset_outs", outs, 10'd0);
    chk_ctrs();
    tick();

    // clean read miss, fill response in 4th ALLOCATE cycle
    access(1, 0, 0, 0, 0, 0, 4, 0);
    // read hit
    access(1, 0, 1, 1, 0, 0, 0, 0);
    // write hit
    access(0, 1, 1, 1, 1, 0, 0, 0);
    // dirty miss, writeback then fill
    access(1, 0, 0, 1, 1, 3, 2, 0);
    // read+write together acts as write, dirty miss
    access(1, 1, 0, 1, 1, 1, 1, 0);
    // valid but clean miss goes straight to fill
    access(0, 1, 0, 1, 0, 0, 3, 0);

    // stray pmem_resp while idle is ignored
    pmem_resp = 1;
    @(negedge clk);
    chk("stray_resp_outs", outs, 10'd0);
    tick();
    pmem_resp = 0;
    access(1, 0, 1, 1, 0, 0, 0, 0);

    // randomized accesses
    for (int n = 0; n < 60; n++) begin
      bit r, wr, h, v, d;
      r = 1'($urandom);
      wr = 1'($urandom);
      if (!r && !wr) r = 1;
      h = ($urandom_range(0, 2) != 0);
      v = 1'($urandom);
      d = 1'($urandom);
      access(r, wr, h, v, d,
             $urandom_range(1, 4), $urandom_range(1, 4), 0);
    end

    // clear together with a hit: clear wins
    access(1, 0, 1, 1, 0, 0, 0, 1);

    // saturate the narrow counters with hits
    for (int n = 0; n < 10; n++)
      access(1, 0, 1, 1, 0, 0, 0, 0);

    // reset in the middle of ALLOCATE
    mem_read = 1;
    cache_hit = 0;
    valid = 0;
    dirty = 0;
    tick();
    @(negedge clk);
    chk("alloc_before_rst", outs,
        pk(0, 1, 0, 0, 0, 0, 2'b00, 0, 0));
    tick();
    rst = 1;
    tick();
    rst = 0;
    mem_read = 0;
    m_hit = 0; m_miss = 0; m_wb = 0; pend = 0;
    @(negedge clk);
    chk("after_rst_pmem_read", {31'd0, pmem_read}, 32'd0);
    chk("after_rst_outs", outs, 10'd0);
    chk_ctrs();
    tick();
    // back in CHECK: a hit answers at once and counts
    access(1, 0, 1, 1, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  // pmem requests must never overlap
  always @(negedge clk) begin
    if (!rst && pmem_read && pmem_write) begin
      checks++;
      fails++;
      $display("FAIL pmem_overlap observed=1 expected=0");
    end
  end

endmodule
